// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared types and constants for the logic-gate truth-table sweep controller.
package gate_sweep_ctrl_pkg;

  localparam int unsigned TT_WIDTH  = 8;
  localparam int unsigned IDX_WIDTH = 3;
  localparam int unsigned CNT_WIDTH = 4;

  // Default expected table: F=1 at minterms 2, 4 and 6.
  localparam logic [TT_WIDTH-1:0] DEFAULT_EXPECT = 8'h54;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/gate_sweep_ctrl_mismatch.sv
// Compares a captured truth table against the expected mask and reports the
// lowest mismatching index.
module gate_sweep_mismatch
  import gate_sweep_ctrl_pkg::*;
(
  input  logic [TT_WIDTH-1:0]  tt_in,
  input  logic [TT_WIDTH-1:0]  exp_mask,
  output logic                 pass_c,
  output logic [IDX_WIDTH-1:0] err_idx_c
);

  logic [TT_WIDTH-1:0] diff;

  // Priority encoder over the difference vector, lowest bit wins.
  always_comb begin
    diff      = tt_in ^ exp_mask;
    pass_c    = (diff == '0);
    err_idx_c = '0;
    for (int i = int'(TT_WIDTH) - 1; i >= 0; i--) begin
      if (diff[i]) err_idx_c = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps A/B/C through all eight input combinations of an external gate,
// captures F for each, and checks the result against an expected table.
module gate_sweep_ctrl
  import gate_sweep_ctrl_pkg::*;
#(
  parameter int unsigned         SETTLE_CYCLES = 1,
  parameter logic [TT_WIDTH-1:0] EXPECT        = DEFAULT_EXPECT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f_in,
  output logic                 a_out,
  output logic                 b_out,
  output logic                 c_out,
  output logic                 busy,
  output logic                 done,
  output logic [TT_WIDTH-1:0]  table_out,
  output logic                 pass,
  output logic [IDX_WIDTH-1:0] err_idx
);

  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] IDX_LAST    = '1;

  state_t               state;
  logic [IDX_WIDTH-1:0] idx;
  logic [CNT_WIDTH-1:0] settle_cnt;
  logic [2:0]           drive;
  logic [TT_WIDTH-1:0]  tt_next;
  logic                 mm_pass;
  logic [IDX_WIDTH-1:0] mm_err;

  assign a_out = drive[2];
  assign b_out = drive[1];
  assign c_out = drive[0];

  // Table as it will look once the current sample is written.
  always_comb begin
    tt_next      = table_out;
    tt_next[idx] = f_in;
  end

  // Verdict is evaluated on the completed table so it lines up with done.
  gate_sweep_mismatch u_mismatch (
    .tt_in     (tt_next),
    .exp_mask  (EXPECT),
    .pass_c    (mm_pass),
    .err_idx_c (mm_err)
  );

  // Sweep FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      drive      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      pass       <= 1'b0;
      err_idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            table_out  <= '0;
            pass       <= 1'b0;
            err_idx    <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            drive      <= '0;
            busy       <= 1'b1;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE, ST_SAMPLE: begin
          if (abort) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            drive      <= '0;
            busy       <= 1'b0;
            table_out  <= '0;
            pass       <= 1'b0;
            err_idx    <= '0;
          end else if (state == ST_DRIVE) begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= '0;
              state      <= ST_SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end else begin
            table_out <= tt_next;
            if (idx == IDX_LAST) begin
              state   <= ST_DONE;
              drive   <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= mm_pass;
              err_idx <= mm_err;
            end else begin
              idx   <= idx + 1'b1;
              drive <= idx + 1'b1;
              state <= ST_DRIVE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl with an external gate model.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, abort0, start3, abort3;
  logic f0, f3;
  logic a0, b0, c0, busy0, done0, pass0;
  logic a3, b3, c3, busy3, done3, pass3;
  logic [7:0] tt0, tt3;
  logic [2:0] err0, err3;

  int gmode;
  bit sel_dut;
  int total;
  int bad;

  typedef struct {
    logic [7:0] tt;
    logic       pass;
    logic [2:0] err;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Gate under test: F = ~C & (A | B), with fault-injection modes.
  function automatic logic gate_f(input int m, input logic [2:0] i);
    logic f;
    f = ~i[0] & (i[2] | i[1]);
    if (m == 1) f = 1'b1;
    if (m == 2 && i == 3'd6) f = 1'b0;
    return f;
  endfunction

  assign f0 = gate_f(gmode, {a0, b0, c0});
  assign f3 = gate_f(gmode, {a3, b3, c3});

  gate_sweep_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_in(f0),
    .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0),
    .table_out(tt0), .pass(pass0), .err_idx(err0)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .f_in(f3),
    .a_out(a3), .b_out(b3), .c_out(c3), .busy(busy3), .done(done3),
    .table_out(tt3), .pass(pass3), .err_idx(err3)
  );

  logic       m_done, m_busy, m_pass;
  logic [2:0] m_abc, m_err;
  logic [7:0] m_tt;
  assign m_done = sel_dut ? done3 : done0;
  assign m_busy = sel_dut ? busy3 : busy0;
  assign m_pass = sel_dut ? pass3 : pass0;
  assign m_abc  = sel_dut ? {a3, b3, c3} : {a0, b0, c0};
  assign m_err  = sel_dut ? err3 : err0;
  assign m_tt   = sel_dut ? tt3 : tt0;

  task automatic set_start(input logic v);
    if (sel_dut) start3 = v;
    else start0 = v;
  endtask

  // Push expectation, launch a sweep, pop and compare when done appears.
  task automatic run_sweep(input string name, input logic [7:0] tt, input logic p,
                           input logic [2:0] e, input int lat, input bit chk_abc,
                           input int restart_at, input bit with_abort);
    exp_t x;
    int c;
    int abc_err;
    x.tt = tt; x.pass = p; x.err = e; x.lat = lat;
    sb.push_back(x);
    @(negedge clk);
    set_start(1'b1);
    if (with_abort) abort0 = 1'b1;
    @(negedge clk);
    set_start(1'b0);
    abort0 = 1'b0;
    c = 0;
    abc_err = 0;
    while (!m_done && c < 200) begin
      if (chk_abc && m_abc !== 3'(c / 4)) abc_err++;
      @(negedge clk);
      c++;
      set_start(c == restart_at);
    end
    set_start(1'b0);
    x = sb.pop_front();
    total++;
    if (!m_done) begin
      bad++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, c);
      return;
    end
    total++;
    if (c !== x.lat) begin
      bad++; $display("FAIL %s_latency: got %0d want %0d", name, c, x.lat);
    end
    total++;
    if (m_tt !== x.tt) begin
      bad++; $display("FAIL %s_table: got %h want %h", name, m_tt, x.tt);
    end
    total++;
    if (m_pass !== x.pass) begin
      bad++; $display("FAIL %s_pass: got %b want %b", name, m_pass, x.pass);
    end
    total++;
    if (m_err !== x.err) begin
      bad++; $display("FAIL %s_err_idx: got %0d want %0d", name, m_err, x.err);
    end
    total++;
    if (m_abc !== 3'b000 || m_busy !== 1'b0) begin
      bad++; $display("FAIL %s_done_idle: abc=%b busy=%b want 000/0", name, m_abc, m_busy);
    end
    if (chk_abc) begin
      total++;
      if (abc_err != 0) begin
        bad++; $display("FAIL %s_abc_steps: got %0d wrong cycles want 0", name, abc_err);
      end
    end
    repeat (3) @(negedge clk);
    total++;
    if (m_done !== 1'b0 || m_tt !== x.tt || m_pass !== x.pass) begin
      bad++;
      $display("FAIL %s_hold: done=%b table=%h pass=%b want 0/%h/%b",
               name, m_done, m_tt, m_pass, x.tt, x.pass);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({a0, b0, c0, busy0, done0, pass0, err0, tt0} !== 17'd0) begin
      bad++; $display("FAIL reset_dut0: got %h want 0", {a0, b0, c0, busy0, done0, pass0, err0, tt0});
    end
    total++;
    if ({a3, b3, c3, busy3, done3, pass3, err3, tt3} !== 17'd0) begin
      bad++; $display("FAIL reset_dut3: got %h want 0", {a3, b3, c3, busy3, done3, pass3, err3, tt3});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_real_gate();
    sel_dut = 1'b0; gmode = 0;
    run_sweep("real", 8'h54, 1'b1, 3'd0, 16, 1'b0, -1, 1'b0);
  endtask

  task automatic test_tied_one();
    sel_dut = 1'b0; gmode = 1;
    run_sweep("tied1", 8'hFF, 1'b0, 3'd0, 16, 1'b0, -1, 1'b0);
  endtask

  task automatic test_bit6_fault();
    sel_dut = 1'b0; gmode = 2;
    run_sweep("bit6", 8'h14, 1'b0, 3'd6, 16, 1'b0, -1, 1'b0);
  endtask

  task automatic test_settle3();
    sel_dut = 1'b1; gmode = 0;
    run_sweep("settle3", 8'h54, 1'b1, 3'd0, 32, 1'b1, -1, 1'b0);
    sel_dut = 1'b0;
  endtask

  task automatic test_abort();
    int c;
    int dones;
    sel_dut = 1'b0; gmode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    c = 0;
    while ({a0, b0, c0} != 3'd3 && c < 50) begin @(negedge clk); c++; end
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    total++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || tt0 !== 8'h00 || pass0 !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear: busy=%b done=%b table=%h pass=%b want 0/0/00/0", busy0, done0, tt0, pass0);
    end
    dones = 0;
    repeat (30) begin @(negedge clk); if (done0) dones++; end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL abort_no_done: got %0d pulses want 0", dones);
    end
    // start and abort together in IDLE: start wins and the sweep completes
    run_sweep("abort_then_start", 8'h54, 1'b1, 3'd0, 16, 1'b0, -1, 1'b1);
  endtask

  task automatic test_restart_ignored();
    int dones;
    sel_dut = 1'b0; gmode = 0;
    run_sweep("restart", 8'h54, 1'b1, 3'd0, 16, 1'b0, 5, 1'b0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done0) dones++; end
    total++;
    if (dones != 0) begin
      bad++; $display("FAIL restart_extra_done: got %0d pulses want 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    int hits;
    sel_dut = 1'b0; gmode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    c = 0;
    while ({a0, b0, c0} != 3'd5 && c < 50) begin @(negedge clk); c++; end
    total++;
    if (tt0 === 8'h00) begin
      bad++; $display("FAIL rstmid_partial: table got %h want nonzero before reset", tt0);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a0, b0, c0, busy0, done0, pass0, err0, tt0} !== 17'd0) begin
      bad++; $display("FAIL rstmid_async: got %h want 0", {a0, b0, c0, busy0, done0, pass0, err0, tt0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (30) begin @(negedge clk); if (done0 || busy0) hits++; end
    total++;
    if (hits != 0) begin
      bad++; $display("FAIL rstmid_no_resume: got %0d busy/done cycles want 0", hits);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    start0 = 1'b0; abort0 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    gmode = 0; sel_dut = 1'b0;
    test_reset();
    test_real_gate();
    test_tied_one();
    test_bit6_fault();
    test_settle3();
    test_abort();
    test_restart_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving cycles the gate inputs are held before sampling; legal range 1..15.
REQ-002 SHALL have parameter EXPECT[7:0], default 8'h54, giving the expected truth table; bit i is F for {A,B,C}=i (A = MSB); 8'h54 means F=1 at minterms 2, 4 and 6.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle request to run a sweep.
REQ-006 abort  input  1  cancels a running sweep.
REQ-007 f_in  input  1  F output of the gate under test.
REQ-008 a_out, b_out, c_out  output  1 each  drive gate inputs A, B, C.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 table_out  output  8  captured truth table, bit i = F at index i.
REQ-012 pass  output  1  result: table_out == EXPECT.
REQ-013 err_idx  output  3  lowest index where table_out differs from EXPECT; 0 when pass=1.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 In IDLE, start=1 at a rising edge SHALL: clear table_out, pass and err_idx; set index to 0; enter DRIVE.
REQ-016 {a_out,b_out,c_out} SHALL equal index[2:], index[1], index[0] in DRIVE and SAMPLE, and SHALL be 3'b000 in IDLE and DONE.
REQ-017 DRIVE SHALL last exactly SETTLE_CYCLES cycles, counted by a settle counter, and then go to SAMPLE.
REQ-018 SAMPLE SHALL last exactly 1 cycle and SHALL write f_in into table_out[index].
REQ-019 From SAMPLE, if index<7 the block SHALL increment index and return to DRIVE; if index==7 it SHALL go to DONE. The index SHALL never wrap.
REQ-020 In DONE, pass and err_idx SHALL be computed from the complete table; done=1 for that single cycle; the FSM SHALL then return to IDLE.
REQ-021 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+8*(SETTLE_CYCLES+1); with the default this is 16 cycles after acceptance.
REQ-022 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-023 start while busy=1, or while in DONE, SHALL be ignored; it SHALL NOT be queued.
REQ-024 abort=1 in DRIVE or SAMPLE SHALL, at the next edge: go to IDLE; leave done=0; clear table_out, pass and err_idx.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 If abort and start are both high in IDLE, start SHALL win; if both are high while busy, abort SHALL win.
REQ-027 table_out, pass and err_idx SHALL hold their values from done until the next accepted start.
REQ-028 err_idx SHALL be a priority encoder over (table_out ^ EXPECT), lowest bit first.

Reset
REQ-029 On rst_n=0, asynchronously and regardless of state, the block SHALL: go to IDLE; set index and the settle counter to 0; drive a/b/c_out, busy, done, pass, table_out and err_idx to 0.
REQ-030 Deassertion of rst_n mid-sweep SHALL NOT resume the sweep; a new start SHALL be required.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (2 bits), the constant TT_WIDTH=8 and the default expected mask 8'h54.
REQ-032 The block SHALL contain one natural sub-module, gate_sweep_mismatch, implementing the combinational priority encoder that produces pass/err_idx from table and expected mask.
REQ-033 The gate under test SHALL be instantiated outside the block; the bench SHALL connect a/b/c_out to it and its F to f_in.

Verification
REQ-034 Default parameters, the real gate attached, start pulse -> done exactly 16 cycles after acceptance; table_out=8'h54; pass=1; err_idx=0.
REQ-035 f_in tied to 1, start -> table_out=8'hFF; pass=0; err_idx=0.
REQ-036 SETTLE_CYCLES=3, real gate, start -> done exactly 32 cycles after acceptance; a/b/c_out step 000..111, each held 4 cycles; pass=1.
REQ-037 abort asserted while index=3 -> next cycle busy=0, done never pulses, table_out=0; a subsequent start runs normally and pass=1.
REQ-038 start re-pulsed mid-sweep -> ignored, with exactly one done pulse; rst_n pulsed low at index 5 -> all outputs 0 immediately, and no done after release.
REQ-039 f_in = real F with bit 6 forced to 0 -> table_out=8'h14; pass=0; err_idx=6.
